// File: rtl/reg_file_pkg.sv
// Shared CPU constants: datapath widths, register-file defaults and ALU SELECT opcodes.
package reg_file_pkg;

    localparam int RF_DATA_W   = 8;
    localparam int RF_NUM_REGS = 8;
    localparam int RF_ADDR_W   = 3;

    localparam int ALU_SEL_W = 3;

    typedef enum logic [ALU_SEL_W-1:0] {
        ALU_FWD = 3'b000,
        ALU_ADD = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_sel_e;

endpackage

// File: rtl/reg_read_port.sv
// One combinational register-file read port: address decode, out-of-range zeroing
// and optional write-to-read forwarding.
module reg_read_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int BYPASS   = 0
) (
    input  logic [NUM_REGS*DATA_W-1:0] regs_i,
    input  logic [ADDR_W-1:0]          addr_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    output logic [DATA_W-1:0]          data_o
);

    logic in_range;
    logic fwd;

    assign in_range = (int'(addr_i) < NUM_REGS);
    assign fwd      = (BYPASS != 0) && wr_en_i && (wr_addr_i == addr_i);

    // Reset and unmapped addresses read zero; forwarding never exposes a discarded write.
    always_comb begin
        data_o = '0;
        if (!rst_i && in_range) begin
            if (fwd) begin
                data_o = wr_data_i;
            end else begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (addr_i == ADDR_W'(i)) data_o = regs_i[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// Two-read, one-write register file with asynchronous clear and optional
// write-to-read bypass.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int BYPASS   = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2
);

    if (NUM_REGS > (2 ** ADDR_W)) begin : g_bad_cfg
        $error("reg_file: NUM_REGS exceeds the address space");
    end

    logic [DATA_W-1:0]          regs_q [NUM_REGS];
    logic [DATA_W-1:0]          regs_d [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] regs_flat;

    // Per-register enable keeps an unknown WRITE/INADDRESS from disturbing other entries.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (WRITE && (INADDRESS == ADDR_W'(i))) regs_d[i] = IN;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
    end

    reg_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .BYPASS   (BYPASS)
    ) u_rd1 (
        .regs_i    (regs_flat),
        .addr_i    (OUT1ADDRESS),
        .rst_i     (RESET),
        .wr_en_i   (WRITE),
        .wr_addr_i (INADDRESS),
        .wr_data_i (IN),
        .data_o    (OUT1)
    );

    reg_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .BYPASS   (BYPASS)
    ) u_rd2 (
        .regs_i    (regs_flat),
        .addr_i    (OUT2ADDRESS),
        .rst_i     (RESET),
        .wr_en_i   (WRITE),
        .wr_addr_i (INADDRESS),
        .wr_data_i (IN),
        .data_o    (OUT2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: three configurations (default, bypass, six registers) driven in
// parallel and compared against an array-based reference model.
module tb_reg_file;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       WRITE = 1'b0;
  logic [7:0] IN = 8'h00;
  logic [2:0] INADDRESS = 3'd0;
  logic [2:0] A1 = 3'd0;
  logic [2:0] A2 = 3'd0;

  logic [7:0] o1_0, o2_0, o1_1, o2_1, o1_2, o2_2;

  always #5 CLK = ~CLK;

  reg_file #(.DATA_W(8), .NUM_REGS(8), .ADDR_W(3), .BYPASS(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(A1), .OUT2ADDRESS(A2), .OUT1(o1_0), .OUT2(o2_0));

  reg_file #(.DATA_W(8), .NUM_REGS(8), .ADDR_W(3), .BYPASS(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(A1), .OUT2ADDRESS(A2), .OUT1(o1_1), .OUT2(o2_1));

  reg_file #(.DATA_W(8), .NUM_REGS(6), .ADDR_W(3), .BYPASS(0)) dut2 (
    .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
    .OUT1ADDRESS(A1), .OUT2ADDRESS(A2), .OUT1(o1_2), .OUT2(o2_2));

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [3][8];
  int         nregs [3] = '{8, 8, 6};
  bit         byp   [3] = '{1'b0, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input int k, input logic [2:0] a);
    if (RESET) return 8'h00;
    if (int'(a) >= nregs[k]) return 8'h00;
    if (byp[k] && WRITE && a == INADDRESS) return IN;
    return mem[k][a];
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 8; r++) mem[k][r] = 8'h00;
  endfunction

  function automatic void model_edge();
    if (RESET) model_clear();
    else if (WRITE)
      for (int k = 0; k < 3; k++)
        if (int'(INADDRESS) < nregs[k]) mem[k][INADDRESS] = IN;
  endfunction

  task automatic check_all(input string tag);
    chk($sformatf("%s/cfg0/out1", tag), o1_0, model_rd(0, A1));
    chk($sformatf("%s/cfg0/out2", tag), o2_0, model_rd(0, A2));
    chk($sformatf("%s/cfg1/out1", tag), o1_1, model_rd(1, A1));
    chk($sformatf("%s/cfg1/out2", tag), o2_1, model_rd(1, A2));
    chk($sformatf("%s/cfg2/out1", tag), o1_2, model_rd(2, A1));
    chk($sformatf("%s/cfg2/out2", tag), o2_2, model_rd(2, A2));
  endtask

  // One cycle: drive at negedge, check before the edge, then check after it.
  task automatic cycle(input string tag, input logic w, input logic [2:0] wa,
                       input logic [7:0] d, input logic [2:0] a1, input logic [2:0] a2,
                       input logic r);
    @(negedge CLK);
    WRITE = w; INADDRESS = wa; IN = d; A1 = a1; A2 = a2; RESET = r;
    if (r) model_clear();
    #1 check_all({tag, "/pre"});
    @(posedge CLK);
    model_edge();
    #1 check_all({tag, "/post"});
  endtask

  initial begin
    model_clear();
    #2 check_all("reset");
    chk("reset/out1", o1_0, 8'h00);

    // Load R3, pulse reset with no clock edge.
    cycle("ld_r3", 1'b1, 3'd3, 8'h5A, 3'd3, 3'd3, 1'b0);
    chk("r3_loaded", o1_0, 8'h5A);
    @(negedge CLK);
    WRITE = 1'b0;
    #1 RESET = 1'b1;
    model_clear();
    #1 chk("async_clr/cfg0", o1_0, 8'h00);
    chk("async_clr/cfg1", o1_1, 8'h00);
    RESET = 1'b0;
    #1 check_all("after_pulse");

    // Two writes on consecutive edges, dual read.
    cycle("w_r2", 1'b1, 3'd2, 8'h11, 3'd0, 3'd0, 1'b0);
    cycle("w_r5", 1'b1, 3'd5, 8'hF0, 3'd2, 3'd5, 1'b0);
    cycle("rd25", 1'b0, 3'd0, 8'h00, 3'd2, 3'd5, 1'b0);
    chk("rd25/out1", o1_0, 8'h11);
    chk("rd25/out2", o2_0, 8'hF0);

    // Bypass versus no bypass on the register being written.
    cycle("w_r4", 1'b1, 3'd4, 8'h01, 3'd4, 3'd4, 1'b0);
    @(negedge CLK);
    WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'h7E; A1 = 3'd4; A2 = 3'd4;
    #1 chk("nobyp_pre", o1_0, 8'h01);
    chk("byp_pre", o1_1, 8'h7E);
    check_all("byp_pre");
    @(posedge CLK);
    model_edge();
    #1 chk("nobyp_post", o1_0, 8'h7E);

    // Back-to-back writes to one register keep the last value.
    cycle("b2b_a", 1'b1, 3'd6, 8'hC3, 3'd6, 3'd1, 1'b0);
    cycle("b2b_b", 1'b1, 3'd6, 8'h3C, 3'd6, 3'd1, 1'b0);
    cycle("b2b_rd", 1'b0, 3'd6, 8'h00, 3'd6, 3'd6, 1'b0);
    chk("b2b/out1", o1_0, 8'h3C);

    // Reset rising on the same edge as a write.
    @(negedge CLK);
    WRITE = 1'b1; IN = 8'hAA; INADDRESS = 3'd1; A1 = 3'd1; A2 = 3'd1;
    @(posedge CLK);
    RESET = 1'b1;
    model_clear();
    #1 chk("rst_edge/cfg0", o1_0, 8'h00);
    @(negedge CLK);
    RESET = 1'b0; WRITE = 1'b0;
    #1 chk("rst_edge_r1/cfg0", o1_0, 8'h00);
    chk("rst_edge_r1/cfg1", o1_1, 8'h00);
    check_all("rst_edge");

    // First write after reset, then out-of-range write on six-register config.
    cycle("post_rst_w", 1'b1, 3'd0, 8'h42, 3'd0, 3'd0, 1'b0);
    chk("post_rst_w/cfg2", o1_2, 8'h42);
    cycle("oor_w", 1'b1, 3'd7, 8'h33, 3'd7, 3'd0, 1'b0);
    chk("oor7/cfg2", o1_2, 8'h00);
    chk("oor0/cfg2", o2_2, 8'h42);
    chk("in7/cfg0", o1_0, 8'h33);
    for (int r = 0; r < 8; r++)
      cycle($sformatf("scan%0d", r), 1'b0, 3'd0, 8'h00, 3'(r), 3'(7 - r), 1'b0);

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      cycle($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            8'($urandom), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
